// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - shared state type, default phase lengths and counter helpers for the pixel sequencer
package pixel_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_EXPOSE,
      ST_CONVERT,
      ST_READ,
      ST_DRAIN
   } ctrl_state_t;

   localparam int DEF_C_ERASE   = 5;
   localparam int DEF_C_EXPOSE  = 255;
   localparam int DEF_C_CONVERT = 255;
   localparam int DEF_C_READ    = 5;

   localparam int FRAME_CNT_W   = 16;
   localparam int CNT_W         = 16;

   // Phase counter runs from dur-1 down to 0; anything below one cycle is stretched to one.
   function automatic logic [CNT_W-1:0] phase_load(input int dur);
      if (dur <= 1) return '0;
      return CNT_W'(dur - 1);
   endfunction

endpackage

// File: rtl/pixel_stream_out.sv
// rtl/pixel_stream_out.sv - captures the pixel buses and streams the words out with valid/ready
module pixel_stream_out #(
   parameter int N_BUS  = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = $clog2(N_BUS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [N_BUS*DATA_W-1:0] bus_i,
   input  logic                    px_ready,
   output logic                    px_valid,
   output logic [DATA_W-1:0]       px_data,
   output logic [IDX_W-1:0]        px_idx,
   output logic                    px_last,
   output logic                    done
);

   logic [N_BUS-1:0][DATA_W-1:0] cap_q, cap_d;
   logic                         valid_q, valid_d;
   logic                         last_q, last_d;
   logic [DATA_W-1:0]            data_q, data_d;
   logic [IDX_W-1:0]             idx_q, idx_d, idx_nxt;

   assign idx_nxt = idx_q + IDX_W'(1);

   always_comb begin
      cap_d   = cap_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      idx_d   = idx_q;
      done    = 1'b0;
      if (load) begin
         cap_d   = bus_i;
         valid_d = 1'b1;
         idx_d   = '0;
         data_d  = bus_i[DATA_W-1:0];
         last_d  = (N_BUS == 1);
      end else if (valid_q && px_ready) begin
         if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            data_d  = '0;
            done    = 1'b1;
         end else begin
            // Output word is pre-registered so px_data never depends on a mux after the flop.
            idx_d  = idx_nxt;
            data_d = cap_q[idx_nxt];
            last_d = (idx_nxt == IDX_W'(N_BUS - 1));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         cap_q   <= cap_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
      end
   end

   assign px_valid = valid_q;
   assign px_data  = data_q;
   assign px_idx   = idx_q;
   assign px_last  = last_q;

endmodule

// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - erase/expose/convert/read frame sequencer for the 2x2 pixel array
// Optional PIXEL_CTRL_CFG_EXPOSE_EN adds cfg_expose, a run-time exposure length sampled at frame start.
module pixel_array_ctrl
   import pixel_ctrl_pkg::*;
#(
   parameter int N_BUS     = 4,
   parameter int DATA_W    = 8,
   parameter int C_ERASE   = DEF_C_ERASE,
   parameter int C_EXPOSE  = DEF_C_EXPOSE,
   parameter int C_CONVERT = DEF_C_CONVERT,
   parameter int C_READ    = DEF_C_READ
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
`ifdef PIXEL_CTRL_CFG_EXPOSE_EN
   input  logic [15:0]                cfg_expose,
`endif
   output logic                       erase,
   output logic                       expose,
   output logic                       convert,
   output logic                       read,
   output logic [DATA_W-1:0]          bus_o,
   output logic                       bus_oe,
   input  logic [N_BUS*DATA_W-1:0]    bus_i,
   output logic                       px_valid,
   input  logic                       px_ready,
   output logic [DATA_W-1:0]          px_data,
   output logic [$clog2(N_BUS)-1:0]   px_idx,
   output logic                       px_last,
   output logic [FRAME_CNT_W-1:0]     frame_cnt
);

   localparam logic [DATA_W-1:0] RAMP_MAX = '1;

   ctrl_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       expose_load;
   logic [DATA_W-1:0]      bus_o_q, bus_o_d;
   logic                   erase_q, erase_d;
   logic                   expose_q, expose_d;
   logic                   convert_q, convert_d;
   logic                   read_q, read_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   start_frame;
   logic                   load;
   logic                   done;

`ifdef PIXEL_CTRL_CFG_EXPOSE_EN
   logic [15:0] expose_len_q, expose_len_d;

   always_comb expose_len_d = start_frame ? cfg_expose : expose_len_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) expose_len_q <= '0;
      else       expose_len_q <= expose_len_d;
   end

   assign expose_load = phase_load(int'(expose_len_q));
`else
   assign expose_load = phase_load(C_EXPOSE);
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_o_d     = '0;
      frame_cnt_d = frame_cnt_q;
      load        = 1'b0;
      start_frame = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) start_frame = 1'b1;
         end
         ST_ERASE: begin
            if (cnt_q == '0) begin
               state_d = ST_EXPOSE;
               cnt_d   = expose_load;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_EXPOSE: begin
            if (cnt_q == '0) begin
               state_d = ST_CONVERT;
               cnt_d   = phase_load(C_CONVERT);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CONVERT: begin
            // Ramp starts at 0 on entry (bus_o_d default) and saturates rather than wrapping.
            if (cnt_q == '0) begin
               state_d = ST_READ;
               cnt_d   = phase_load(C_READ);
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               bus_o_d = (bus_o_q == RAMP_MAX) ? RAMP_MAX : bus_o_q + DATA_W'(1);
            end
         end
         ST_READ: begin
            if (cnt_q == '0) begin
               state_d = ST_DRAIN;
               load    = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (done) begin
               frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
               if (run) start_frame = 1'b1;
               else     state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start_frame) begin
         state_d = ST_ERASE;
         cnt_d   = phase_load(C_ERASE);
      end
      erase_d   = (state_d == ST_ERASE);
      expose_d  = (state_d == ST_EXPOSE);
      convert_d = (state_d == ST_CONVERT);
      read_d    = (state_d == ST_READ);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bus_o_q     <= '0;
         erase_q     <= 1'b0;
         expose_q    <= 1'b0;
         convert_q   <= 1'b0;
         read_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_o_q     <= bus_o_d;
         erase_q     <= erase_d;
         expose_q    <= expose_d;
         convert_q   <= convert_d;
         read_q      <= read_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   pixel_stream_out #(
      .N_BUS  (N_BUS),
      .DATA_W (DATA_W),
      .IDX_W  ($clog2(N_BUS))
   ) u_stream (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .bus_i    (bus_i),
      .px_ready (px_ready),
      .px_valid (px_valid),
      .px_data  (px_data),
      .px_idx   (px_idx),
      .px_last  (px_last),
      .done     (done)
   );

   assign erase     = erase_q;
   assign expose    = expose_q;
   assign convert   = convert_q;
   assign read      = read_q;
   assign bus_o     = bus_o_q;
   assign bus_oe    = convert_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - scoreboard bench for pixel_array_ctrl (default build)
module tb_pixel_array_ctrl;

   localparam int C_READ = 5;

   typedef struct {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        px_ready = 1'b1;
   logic [31:0] bus_i = '0;
   logic        erase, expose, convert, read, bus_oe, px_valid, px_last;
   logic [7:0]  bus_o, px_data;
   logic [1:0]  px_idx;
   logic [15:0] frame_cnt;

   logic        run_s = 1'b0;
   logic        px_ready_s = 1'b1;
   logic [31:0] bus_i_s = '0;
   logic        erase_s, expose_s, convert_s, read_s, bus_oe_s, px_valid_s, px_last_s;
   logic [7:0]  bus_o_s, px_data_s;
   logic [1:0]  px_idx_s;
   logic [15:0] frame_cnt_s;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_excl = 0;
   bit   sat_done = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   pixel_array_ctrl dut (
      .clk(clk), .reset(reset), .run(run),
      .erase(erase), .expose(expose), .convert(convert), .read(read),
      .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i),
      .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
      .px_idx(px_idx), .px_last(px_last), .frame_cnt(frame_cnt)
   );

   pixel_array_ctrl #(.C_EXPOSE(2), .C_CONVERT(300)) dut_sat (
      .clk(clk), .reset(reset), .run(run_s),
      .erase(erase_s), .expose(expose_s), .convert(convert_s), .read(read_s),
      .bus_o(bus_o_s), .bus_oe(bus_oe_s), .bus_i(bus_i_s),
      .px_valid(px_valid_s), .px_ready(px_ready_s), .px_data(px_data_s),
      .px_idx(px_idx_s), .px_last(px_last_s), .frame_cnt(frame_cnt_s)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic phase(input int p);
      case (p)
         0:       return erase;
         1:       return expose;
         2:       return convert;
         default: return read;
      endcase
   endfunction

   function automatic int exp_dur(input int p);
      case (p)
         0:       return 5;
         1:       return 255;
         2:       return 255;
         default: return C_READ;
      endcase
   endfunction

   // Stream monitor: pops the scoreboard on every handshake.
   always @(negedge clk) begin
      if ($countones({erase, expose, convert, read}) > 1 ||
          (px_valid && (erase || expose || convert || read)))
         n_excl++;
      if (px_valid && px_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got idx %0d data 0x%0h, nothing expected", px_idx, px_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("px_data", px_data, mon_e.data);
            check("px_idx", px_idx, mon_e.idx);
            check("px_last", px_last, mon_e.last);
         end
      end
   end

   task automatic check_quiet(input string tag);
      check({tag, "_phases"}, {erase, expose, convert, read}, 4'b0);
      check({tag, "_bus"}, {bus_oe, bus_o}, 9'b0);
      check({tag, "_px"}, {px_valid, px_last, px_idx, px_data}, '0);
      check({tag, "_frame_cnt"}, frame_cnt, 16'd0);
   endtask

   task automatic do_frame(input logic [31:0] word, input bit drop_run);
      int   gap;
      int   len;
      exp_t e;
      for (int p = 0; p < 4; p++) begin
         gap = 0;
         while (!phase(p) && gap < 3000) begin
            @(negedge clk);
            gap++;
         end
         if (p == 0) check("erase_start", phase(0), 1'b1);
         else        check($sformatf("gap_before_phase%0d", p), gap, 0);
         len = 0;
         while (phase(p) && len < 1000) begin
            if (p == 1 && drop_run && len == 10) run = 1'b0;
            if (p == 2) begin
               check("ramp", bus_o, (len > 255) ? 255 : len);
               check("bus_oe_convert", bus_oe, 1'b1);
            end
            if (p == 3) begin
               check("bus_o_read", {bus_oe, bus_o}, 9'b0);
               if (len == C_READ - 1) begin
                  bus_i = word;
                  for (int k = 0; k < 4; k++) begin
                     e.data = word[k*8 +: 8];
                     e.idx  = 2'(k);
                     e.last = (k == 3);
                     exp_q.push_back(e);
                  end
               end else begin
                  bus_i = ~word;
               end
            end
            len++;
            @(negedge clk);
         end
         check($sformatf("len_phase%0d", p), len, exp_dur(p));
      end
      bus_i = ~word;
   endtask

   task automatic wait_drain_end(input int exp_cyc);
      int cyc = 0;
      while (px_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_cycles", cyc, exp_cyc);
   endtask

   initial begin
      @(negedge clk);
      check_quiet("reset");
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b1;

      // Frame 1: default timing, free-flowing stream
      check("frame_cnt_pre", frame_cnt, 16'd0);
      do_frame(32'h4433_2211, 1'b0);
      check("frame_cnt_in_drain", frame_cnt, 16'd0);
      wait_drain_end(4);
      check("frame_cnt_1", frame_cnt, 16'd1);
      check("next_erase_1", erase, 1'b1);

      // Frame 2: backpressure held for 20 cycles at the first word
      px_ready = 1'b0;
      do_frame(32'h4433_2211, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check("bp_valid", px_valid, 1'b1);
         check("bp_data", px_data, 8'h11);
         check("bp_idx", px_idx, 2'd0);
         check("bp_phases", {erase, expose, convert, read}, 4'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #2 px_ready = 1'b1;
      @(negedge clk);
      wait_drain_end(4);
      check("frame_cnt_2", frame_cnt, 16'd2);
      check("next_erase_2", erase, 1'b1);

      // Frame 3: run dropped during EXPOSE, frame completes then idles
      do_frame(32'hD4C3_B2A1, 1'b1);
      wait_drain_end(4);
      check("frame_cnt_3", frame_cnt, 16'd3);
      for (int i = 0; i < 10; i++) begin
         check("idle_quiet", {erase, expose, convert, read, px_valid}, 5'b0);
         @(negedge clk);
      end

      // Frame 4: asynchronous reset mid-CONVERT, then a clean frame
      run = 1'b1;
      for (int g = 0; g < 3000 && !convert; g++) @(negedge clk);
      check("convert_reached", convert, 1'b1);
      repeat (50) @(negedge clk);
      #1 reset = 1'b1;
      #1 check_quiet("mid_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_frame(32'h8877_6655, 1'b0);
      wait_drain_end(4);
      check("frame_cnt_after_reset", frame_cnt, 16'd1);
      run = 1'b0;

      for (int g = 0; g < 5000 && !sat_done; g++) @(negedge clk);
      check("sat_done", sat_done, 1'b1);
      check("scoreboard_empty", exp_q.size(), 0);
      check("phase_exclusive", n_excl, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Saturating ramp on the long-convert instance
   initial begin
      int len;
      int g;
      wait (!reset);
      @(negedge clk);
      run_s = 1'b1;
      g = 0;
      while (!convert_s && g < 2000) begin
         @(negedge clk);
         g++;
      end
      len = 0;
      while (convert_s && len < 1000) begin
         check("sat_ramp", bus_o_s, (len > 255) ? 255 : len);
         len++;
         @(negedge clk);
      end
      check("sat_convert_len", len, 300);
      check("sat_bus_o_after", bus_o_s, 8'h00);
      run_s    = 1'b0;
      sat_done = 1'b1;
   end

endmodule
